// File: rtl/alu_seq.sv
// alu_seq: WIDTH-bit registered ALU with a start/done handshake.
// Define ALU_DIV_EN to build the iterative restoring DIV/MOD divider.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       aluctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] rez,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             dz,
  output logic             busy,
  output logic             done
);
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;
  logic             is_add, is_sub, is_arith, is_div, lt, co, ov;
  logic [WIDTH-1:0] bop, res;
  logic [WIDTH:0]   sum;
  assign is_add   = aluctrl == OP_ADD;
  assign is_sub   = aluctrl == OP_SUB;
  assign is_arith = is_add | is_sub;
  assign is_div   = aluctrl[2:1] == 2'b10;
  // SUB is A + ~B + 1, so COUT=1 means no borrow
  assign bop = is_sub ? ~b : b;
  assign sum = {1'b0, a} + {1'b0, bop} + {{WIDTH{1'b0}}, is_sub | (is_add & cin)};
  assign lt  = $signed(a) < $signed(b);
  assign co  = is_arith & sum[WIDTH];
  assign ov  = is_arith & (a[WIDTH-1] == bop[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
  assign res = aluctrl == OP_AND ? a & b :
               aluctrl == OP_OR  ? a | b :
               aluctrl == OP_XOR ? a ^ b :
               aluctrl == OP_SLT ? {{(WIDTH-1){1'b0}}, lt} :
               is_arith          ? sum[WIDTH-1:0] : '0;
`ifdef ALU_DIV_EN
  typedef enum logic {IDLE, DIVIDE} state_t;
  localparam int CW = $clog2(WIDTH);
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd, dvs, rem, rem_nx, q_nx, fin;
  logic [WIDTH:0]   shl;
  logic             op_mod, ge;
  // dvd shifts the dividend out of its MSB while quotient bits enter at the LSB
  assign shl    = {rem, dvd[WIDTH-1]};
  assign ge     = shl >= {1'b0, dvs};
  assign rem_nx = ge ? shl[WIDTH-1:0] - dvs : shl[WIDTH-1:0];
  assign q_nx   = {dvd[WIDTH-2:0], ge};
  assign fin    = op_mod ? rem_nx : q_nx;
  assign busy   = state == DIVIDE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      op_mod <= 1'b0;
      rez    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
      dz     <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start && is_div) begin
          state  <= DIVIDE;
          dvd    <= a;
          dvs    <= b;
          rem    <= '0;
          cnt    <= '0;
          op_mod <= aluctrl[0];
        end else if (start) begin
          rez  <= res;
          cout <= co;
          ovf  <= ov;
          zero <= res == '0;
          dz   <= 1'b0;
          done <= 1'b1;
        end
      end else begin
        dvd <= q_nx;
        rem <= rem_nx;
        cnt <= cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          state <= IDLE;
          rez   <= fin;
          zero  <= fin == '0;
          cout  <= 1'b0;
          ovf   <= 1'b0;
          dz    <= dvs == '0;
          done  <= 1'b1;
        end
      end
    end
`else
  assign busy = 1'b0;
  // without the divider, DIV/MOD finish at once with REZ=0 and DZ=1
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rez  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
      dz   <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= start;
      if (start) begin
        rez  <= res;
        cout <= co;
        ovf  <= ov;
        zero <= res == '0;
        dz   <= is_div;
      end
    end
`endif
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table-driven checks of alu_seq single-cycle ops plus directed
// divider/handshake sequences (divider sequences built when ALU_DIV_EN is defined).
module tb_alu_seq;
  localparam int W = 16;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   aluctrl = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic [W-1:0] rez;
  logic         cout, ovf, zero, dz, busy, done;
  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .aluctrl(aluctrl), .a(a), .b(b), .cin(cin),
    .rez(rez), .cout(cout), .ovf(ovf), .zero(zero), .dz(dz), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] r;
    logic [3:0]   f;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic c, input logic [W-1:0] r, input logic [3:0] f);
    vec_t v;
    v.op = op; v.a = x; v.b = y; v.cin = c; v.r = r; v.f = f;
    vt.push_back(v);
  endtask

`ifdef ALU_DIV_EN
  task automatic div_check(input string name, input logic [2:0] op, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic [W-1:0] er, input logic edz,
                           input logic poke);
    int bad;
    aluctrl = op; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    a = 16'h5555; b = 16'h0003; aluctrl = 3'b010;
    bad = (busy !== 1'b1 || done !== 1'b0) ? 1 : 0;
    for (int i = 1; i < W; i++) begin
      start = poke;
      tick();
      if (busy !== 1'b1 || done !== 1'b0) bad++;
    end
    start = 1'b0;
    chk({name, ".busy_window"}, bad, 0);
    tick();
    chk({name, ".done_busy"}, {done, busy}, 2'b10);
    chk({name, ".rez"}, rez, er);
    chk({name, ".flags"}, {cout, ovf, zero, dz}, {2'b00, er == '0, edz});
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // flags = {cout, ovf, zero, dz}
    add_vec(3'b010, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b0100);
    add_vec(3'b110, 16'h1234, 16'h1234, 1'b0, 16'h0000, 4'b1010);
    add_vec(3'b111, 16'hFFFF, 16'h0001, 1'b0, 16'h0001, 4'b0000);
    add_vec(3'b111, 16'h0001, 16'hFFFF, 1'b0, 16'h0000, 4'b0010);
    add_vec(3'b000, 16'hF0F0, 16'h0FF0, 1'b0, 16'h00F0, 4'b0000);
    add_vec(3'b001, 16'hF0F0, 16'h0FF0, 1'b0, 16'hFFF0, 4'b0000);
    add_vec(3'b011, 16'hF0F0, 16'h0FF0, 1'b0, 16'hFF00, 4'b0000);
    add_vec(3'b010, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 4'b1010);
    add_vec(3'b110, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 4'b0000);
    add_vec(3'b110, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 4'b1100);
    add_vec(3'b010, 16'h1234, 16'h1111, 1'b1, 16'h2346, 4'b0000);
    add_vec(3'b110, 16'h0005, 16'h0003, 1'b1, 16'h0002, 4'b1000);
    add_vec(3'b010, 16'h8000, 16'h8000, 1'b0, 16'h0000, 4'b1110);
    add_vec(3'b111, 16'h8000, 16'h7FFF, 1'b0, 16'h0001, 4'b0000);
`ifndef ALU_DIV_EN
    add_vec(3'b100, 16'h0064, 16'h0007, 1'b0, 16'h0000, 4'b0011);
    add_vec(3'b101, 16'hABCD, 16'h0000, 1'b0, 16'h0000, 4'b0011);
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {rez, cout, ovf, zero, dz, busy, done}, '0);
    rst_n = 1'b1;
    tick();
    chk("idle_no_done", {busy, done}, 2'b00);
    // back-to-back: START held high, one result per cycle
    for (int i = 0; i < vt.size(); i++) begin
      aluctrl = vt[i].op; a = vt[i].a; b = vt[i].b; cin = vt[i].cin; start = 1'b1;
      tick();
      chk($sformatf("v%0d.done", i), {done, busy}, 2'b10);
      chk($sformatf("v%0d.rez", i), rez, vt[i].r);
      chk($sformatf("v%0d.flags", i), {cout, ovf, zero, dz}, vt[i].f);
    end
    start = 1'b0;
    a = 16'h1111; b = 16'h2222;
    tick();
    chk("done_falls", done, 1'b0);
    chk("rez_holds", rez, vt[vt.size()-1].r);
`ifdef ALU_DIV_EN
    div_check("div1000_7", 3'b100, 16'd1000, 16'd7, 16'd142, 1'b0, 1'b0);
    div_check("mod1000_7", 3'b101, 16'd1000, 16'd7, 16'd6, 1'b0, 1'b0);
    div_check("div_by0", 3'b100, 16'hABCD, 16'h0000, 16'hFFFF, 1'b1, 1'b0);
    div_check("mod_by0", 3'b101, 16'hABCD, 16'h0000, 16'hABCD, 1'b1, 1'b0);
    div_check("div_poked", 3'b100, 16'd1000, 16'd7, 16'd142, 1'b0, 1'b1);
    // START in the DONE cycle is accepted
    aluctrl = 3'b000; a = 16'hF0F0; b = 16'h0FF0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_cycle_start.rez", rez, 16'h00F0);
    chk("done_cycle_start.done", {done, busy}, 2'b10);
    tick();
    chk("single_pulse", done, 1'b0);
    // reset mid-division aborts it
    aluctrl = 3'b100; a = 16'd100; b = 16'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("mid_div_busy", busy, 1'b1);
    rst_n = 1'b0;
    #2;
    chk("mid_div_reset", {rez, cout, ovf, zero, dz, busy, done}, '0);
    tick();
    rst_n = 1'b1;
    begin
      int pulses = 0;
      for (int i = 0; i < W + 4; i++) begin
        tick();
        if (done !== 1'b0 || busy !== 1'b0) pulses++;
      end
      chk("aborted_no_done", pulses, 0);
    end
    div_check("after_abort", 3'b100, 16'd100, 16'd7, 16'd14, 1'b0, 1'b0);
`else
    // reset clears a held result asynchronously
    aluctrl = 3'b001; a = 16'h00FF; b = 16'h0F00; start = 1'b1;
    tick();
    start = 1'b0;
    chk("pre_reset_rez", rez, 16'h0FFF);
    rst_n = 1'b0;
    #2;
    chk("async_reset", {rez, cout, ovf, zero, dz, busy, done}, '0);
    tick();
    rst_n = 1'b1;
    tick();
    aluctrl = 3'b100; a = 16'd1000; b = 16'd7; start = 1'b1;
    tick();
    start = 1'b0;
    chk("nodiv_div.rez", rez, 16'h0000);
    chk("nodiv_div.flags", {done, busy, cout, ovf, zero, dz}, 6'b100011);
    aluctrl = 3'b000; a = 16'hF0F0; b = 16'h0FF0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_cycle_start.rez", rez, 16'h00F0);
    chk("done_cycle_start.dz", {done, dz}, 2'b10);
    tick();
    chk("single_pulse", done, 1'b0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
